// File: rtl/serial_bcd_xs3_codec_if.sv
// Serial Excess-3/BCD codec bus: bit stream in, converted bit and flags out.
// The master drives the stream; the codec is the slave.
interface serial_bcd_xs3_codec_if;
  logic Valid;
  logic Mode;
  logic X;
  logic Z;
  logic DigitDone;
  logic WordDone;
  logic DigitErr;
  logic WordErr;

  modport master (
    output Valid,
    output Mode,
    output X,
    input  Z,
    input  DigitDone,
    input  WordDone,
    input  DigitErr,
    input  WordErr
  );

  modport slave (
    input  Valid,
    input  Mode,
    input  X,
    output Z,
    output DigitDone,
    output WordDone,
    output DigitErr,
    output WordErr
  );
endinterface

// File: rtl/serial_bcd_xs3_codec.sv
// Bit-serial LSB-first Excess-3 <-> BCD converter for NUM_DIGITS-digit words.
// Mealy output on Z; registered digit/word completion and range-error flags.
module serial_bcd_xs3_codec #(
  parameter int NUM_DIGITS = 1
) (
  input logic Clk,
  input logic Rst,
  serial_bcd_xs3_codec_if.slave bus
);

  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DW-1:0] LAST_DIG = DW'(NUM_DIGITS - 1);

  logic [1:0]    bit_idx,   bit_idx_n;
  logic [DW-1:0] digit_idx, digit_idx_n;
  logic          carry,     carry_n;
  logic          mode_q,    mode_q_n;
  logic [2:0]    sr,        sr_n;
  logic          ddone,     ddone_n;
  logic          wdone,     wdone_n;
  logic          derr,      derr_n;
  logic          werr,      werr_n;

  logic       beat;
  logic       first;
  logic       m;
  logic [3:0] kvec;
  logic       k;
  logic       cin;
  logic       cout;
  logic [3:0] d;
  logic       inv;
  logic       last_bit;
  logic       last_dig;

  assign beat     = bus.Valid & ~Rst;
  assign first    = (bit_idx == 2'd0) && (digit_idx == '0);
  assign m        = first ? bus.Mode : mode_q;
  assign last_bit = (bit_idx == 2'd3);
  assign last_dig = (digit_idx == LAST_DIG);

  // +3 when encoding, -3 (two's complement 1101) when decoding
  always_comb begin
    kvec = 4'b1101;
    unique case (1'b1)
      m:       kvec = 4'b0011;
      default: kvec = 4'b1101;
    endcase
  end

  assign k    = kvec[bit_idx];
  assign cin  = (bit_idx != 2'd0) & carry;
  assign cout = (bus.X & k) | (bus.X & cin) | (k & cin);

  assign d   = {bus.X, sr};
  assign inv = m ? (d > 4'd9) : ((d < 4'd3) || (d > 4'd12));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      bit_idx   <= 2'd0;
      digit_idx <= '0;
      carry     <= 1'b0;
      mode_q    <= 1'b0;
      sr        <= 3'd0;
      ddone     <= 1'b0;
      wdone     <= 1'b0;
      derr      <= 1'b0;
      werr      <= 1'b0;
    end else begin
      bit_idx   <= bit_idx_n;
      digit_idx <= digit_idx_n;
      carry     <= carry_n;
      mode_q    <= mode_q_n;
      sr        <= sr_n;
      ddone     <= ddone_n;
      wdone     <= wdone_n;
      derr      <= derr_n;
      werr      <= werr_n;
    end
  end

  always_comb begin
    bit_idx_n   = bit_idx;
    digit_idx_n = digit_idx;
    carry_n     = carry;
    mode_q_n    = mode_q;
    sr_n        = sr;
    ddone_n     = 1'b0;
    wdone_n     = 1'b0;
    derr_n      = 1'b0;
    werr_n      = werr;
    if (beat) begin
      bit_idx_n = bit_idx + 2'd1;
      carry_n   = cout;
      sr_n      = {bus.X, sr[2:1]};
      if (first) begin
        mode_q_n = bus.Mode;
        werr_n   = 1'b0;
      end
      if (last_bit) begin
        ddone_n = 1'b1;
        derr_n  = inv;
        wdone_n = last_dig;
        if (inv) werr_n = 1'b1;
        digit_idx_n = last_dig ? '0 : digit_idx + 1'b1;
      end
    end
  end

  always_comb begin
    bus.Z         = beat & (bus.X ^ k ^ cin);
    bus.DigitDone = ddone;
    bus.WordDone  = wdone;
    bus.DigitErr  = derr;
    bus.WordErr   = werr;
  end

endmodule

// File: tb/tb_serial_bcd_xs3_codec.sv
// Bench for serial_bcd_xs3_codec: directed cases plus randomized words
// against a digit-level arithmetic model, on 1-, 2- and 3-digit instances.
module tb_serial_bcd_xs3_codec;

  logic clk;
  logic rst;
  logic [2:0] valid, mode, x;
  logic [2:0] z, dd, wd, de, we;

  int checks = 0;
  int errors = 0;
  int nd [3] = '{1, 2, 3};
  int dig [3];
  bit mq [3];
  bit werr [3];
  int wd_cnt [3];
  int de_cnt [3];

  serial_bcd_xs3_codec_if if0 ();
  serial_bcd_xs3_codec_if if1 ();
  serial_bcd_xs3_codec_if if2 ();

  assign if0.Valid = valid[0];
  assign if0.Mode  = mode[0];
  assign if0.X     = x[0];
  assign if1.Valid = valid[1];
  assign if1.Mode  = mode[1];
  assign if1.X     = x[1];
  assign if2.Valid = valid[2];
  assign if2.Mode  = mode[2];
  assign if2.X     = x[2];

  assign z  = {if2.Z, if1.Z, if0.Z};
  assign dd = {if2.DigitDone, if1.DigitDone, if0.DigitDone};
  assign wd = {if2.WordDone, if1.WordDone, if0.WordDone};
  assign de = {if2.DigitErr, if1.DigitErr, if0.DigitErr};
  assign we = {if2.WordErr, if1.WordErr, if0.WordErr};

  serial_bcd_xs3_codec #(.NUM_DIGITS(1)) u_d1 (.Clk(clk), .Rst(rst), .bus(if0));
  serial_bcd_xs3_codec #(.NUM_DIGITS(2)) u_d2 (.Clk(clk), .Rst(rst), .bus(if1));
  serial_bcd_xs3_codec #(.NUM_DIGITS(3)) u_d3 (.Clk(clk), .Rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      dig[i]  = 0;
      mq[i]   = 1'b0;
      werr[i] = 1'b0;
    end
  endtask

  // One cycle on instance u, starting and ending at a falling edge.
  task automatic cyc(int u, bit v, bit md, bit xb,
                     bit ez, bit edd, bit ewd, bit ede, bit ewe);
    valid[u] = v;
    mode[u]  = md;
    x[u]     = xb;
    #1;
    check($sformatf("u%0d z", u), 32'(z[u]), 32'(ez));
    @(posedge clk);
    @(negedge clk);
    check($sformatf("u%0d ddone", u), 32'(dd[u]), 32'(edd));
    check($sformatf("u%0d wdone", u), 32'(wd[u]), 32'(ewd));
    check($sformatf("u%0d derr", u), 32'(de[u]), 32'(ede));
    check($sformatf("u%0d werr", u), 32'(we[u]), 32'(ewe));
    if (wd[u]) wd_cnt[u]++;
    if (de[u]) de_cnt[u]++;
    valid[u] = 1'b0;
  endtask

  // Send digit d; md is the mode offered on this beat (used at word start).
  // After bit st, insert ns stall cycles.
  task automatic send_digit(int u, bit md, logic [3:0] d, int st, int ns);
    bit first, m, inv, lastd, mdv;
    logic [3:0] r;
    first = (dig[u] == 0);
    m = first ? md : mq[u];
    if (first) begin
      mq[u]   = md;
      werr[u] = 1'b0;
    end
    r = d + (m ? 4'd3 : 4'd13);
    inv = m ? (d > 4'd9) : ((d < 4'd3) || (d > 4'd12));
    lastd = (dig[u] == nd[u] - 1);
    for (int i = 0; i < 4; i++) begin
      mdv = (first && i == 0) ? md : 1'($urandom);
      if (i == 3 && inv) werr[u] = 1'b1;
      cyc(u, 1'b1, mdv, d[i], r[i], i == 3, i == 3 && lastd,
          i == 3 && inv, werr[u]);
      if (i == st)
        repeat (ns)
          cyc(u, 1'b0, 1'($urandom), 1'($urandom), 1'b0,
              1'b0, 1'b0, 1'b0, werr[u]);
    end
    dig[u] = lastd ? 0 : dig[u] + 1;
  endtask

  task automatic rand_run(int u, bit md, int words);
    logic [3:0] d;
    int st, ns;
    wd_cnt[u] = 0;
    de_cnt[u] = 0;
    for (int w = 0; w < words; w++)
      for (int j = 0; j < nd[u]; j++) begin
        d  = md ? 4'($urandom_range(0, 9)) : 4'($urandom_range(3, 12));
        st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
        ns = $urandom_range(1, 3);
        send_digit(u, md, d, st, ns);
      end
    check($sformatf("u%0d wdcount", u), 32'(wd_cnt[u]), 32'(words));
    check($sformatf("u%0d decount", u), 32'(de_cnt[u]), 32'd0);
  endtask

  initial begin
    valid = '0;
    mode  = '0;
    x     = '0;
    rst   = 1'b1;
    model_reset();
    @(negedge clk);
    valid = '1;
    x     = '1;
    #1;
    for (int u = 0; u < 3; u++) begin
      check($sformatf("u%0d rst z", u), 32'(z[u]), 32'd0);
      check($sformatf("u%0d rst dd", u), 32'(dd[u]), 32'd0);
      check($sformatf("u%0d rst wd", u), 32'(wd[u]), 32'd0);
      check($sformatf("u%0d rst de", u), 32'(de[u]), 32'd0);
      check($sformatf("u%0d rst we", u), 32'(we[u]), 32'd0);
    end
    valid = '0;
    x     = '0;
    @(negedge clk);
    rst = 1'b0;

    send_digit(0, 1'b0, 4'b0111, -1, 0);
    send_digit(0, 1'b1, 4'b1001, -1, 0);
    send_digit(0, 1'b0, 4'b0000, -1, 0);
    cyc(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, werr[0]);
    check("werr sticky", 32'(we[0]), 32'd1);

    send_digit(1, 1'b0, 4'b1100, 1, 3);
    send_digit(1, 1'b0, 4'b0011, -1, 0);

    cyc(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst   = 1'b1;
    valid = '1;
    x     = '1;
    #1;
    check("rst z", 32'(z[0]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst dd", 32'(dd[0]), 32'd0);
    check("rst we", 32'(we[0]), 32'd0);
    valid = '0;
    x     = '0;
    rst   = 1'b0;
    model_reset();
    send_digit(0, 1'b1, 4'b0101, -1, 0);

    for (int u = 0; u < 3; u++) begin
      if (dig[u] == 0) begin
        for (int j = 0; j < 4 * nd[u]; j++)
          send_digit(u, 1'($urandom), 4'($urandom), -1, 0);
      end
    end

    rand_run(0, 1'b0, 2000);
    rand_run(0, 1'b1, 2000);
    rand_run(2, 1'b0, 667);
    rand_run(2, 1'b1, 667);
    rand_run(1, 1'b0, 100);
    rand_run(1, 1'b1, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
